instr_mem_loader: RTL and testbench

- Writer side of the instruction memory. Receives a program image as a byte stream with a valid/ready handshake.
- Packs every three bytes into one 20-bit instruction word and issues one write per word into the instruction array.
- Writes use the same byte-address stride of 4 that fetch uses. Sits between the host/UART byte source and the instruction memory write port; runs before the core is released from reset.

---
 rtl/instr_mem_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: unpacks a length-prefixed byte stream into
// 20-bit instruction words and writes them at a 4-byte stride.
module instr_mem_loader #(
    parameter int                 ADDR_W    = 20,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 MAX_WORDS = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [19:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_written
);

    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, DONE, ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [19:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       ww_q, ww_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic [15:0]       len_full;
    logic [15:0]       ww_inc;

    assign accept   = byte_valid & ready_q;
    assign len_full = {byte_data, len_q[7:0]};
    assign ww_inc   = ww_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        ww_d    = ww_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_LO;
                    ww_d    = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_data;
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if (len_full > MAX_LEN) begin
                        state_d = ERR;
                    end else begin
                        state_d = B0;
                    end
                end
            end
            B0: begin
                if (accept) begin
                    b0_d    = byte_data;
                    state_d = B1;
                end
            end
            B1: begin
                if (accept) begin
                    b1_d    = byte_data;
                    state_d = B2;
                end
            end
            B2: begin
                // Upper nibble of the top byte must be zero for a 20-bit word
                if (accept) begin
                    if (byte_data[7:4] != 4'd0) begin
                        state_d = ERR;
                    end else begin
                        wdata_d = {byte_data[3:0], b1_q, b0_q};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                ww_d    = ww_inc;
                addr_d  = addr_q + ADDR_W'(4);
                state_d = (ww_inc == len_q) ? DONE : B0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q
    always_comb begin
        ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                  (state_d == B0) || (state_d == B1) || (state_d == B2);
        we_d    = (state_d == WRITE);
        busy_d  = ready_d || we_d;
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            wdata_q <= '0;
            addr_q  <= BASE_ADDR;
            ww_q    <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            ww_q    <= ww_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready    = ready_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the
// stimulus and checked by an independent write monitor.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [19:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    typedef struct {
        logic [19:0] addr;
        logic [19:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we cycle must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
            chk("ready_in_write", 32'(byte_ready), 32'd0);
        end
    end

    task automatic push(input logic [19:0] a, input logic [19:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        int n = 0;
        bit sent = 0;
        while (!sent && n < 200) begin
            @(negedge clk);
            n++;
            if (stall && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                if (byte_ready) begin
                    @(posedge clk);
                    #1 byte_valid = 1'b0;
                    sent = 1;
                end
            end
        end
        if (!sent) begin
            checks++;
            errors++;
            byte_valid = 1'b0;
            $display("FAIL send_timeout: byte %0h not accepted expected accept", b);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: done %0b error %0b expected one set", done, error);
        end
    endtask

    task automatic send_two_words(input bit stall);
        send(8'h34, stall); send(8'h12, stall); send(8'h05, stall);
        send(8'hFF, stall); send(8'hEE, stall); send(8'h0A, stall);
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_ww", 32'(words_written), 0);
        #20 rst_n = 1'b1;

        // Normal load, no stalls
        pulse_start();
        chk("a_busy", 32'(busy), 1);
        push(20'h0, 20'h51234);
        push(20'h4, 20'hAEEFF);
        send(8'h02, 0); send(8'h00, 0);
        send_two_words(0);
        wait_end();
        chk("a_done", 32'(done), 1);
        chk("a_error", 32'(error), 0);
        chk("a_ww", 32'(words_written), 2);
        chk("a_busy_end", 32'(busy), 0);
        chk("a_addr_end", 32'(mem_addr), 8);

        // Reset mid-stream
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h34, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_ready", 32'(byte_ready), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_we", 32'(mem_we), 0);
        chk("mr_wdata", 32'(mem_wdata), 0);
        chk("mr_ww", 32'(words_written), 0);
        chk("mr_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h12;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr_idle_ready", 32'(byte_ready), 0);
        end
        byte_valid = 1'b0;

        // Zero length
        pulse_start();
        send(8'h00, 0); send(8'h00, 0);
        wait_end();
        chk("z_done", 32'(done), 1);
        chk("z_ww", 32'(words_written), 0);

        // Restart from DONE, backpressure, start ignored while busy
        pulse_start();
        chk("r_done_clr", 32'(done), 0);
        chk("r_busy", 32'(busy), 1);
        chk("r_addr", 32'(mem_addr), 0);
        push(20'h0, 20'h51234);
        push(20'h4, 20'hAEEFF);
        send(8'h02, 1); send(8'h00, 1);
        send(8'h34, 1);
        pulse_start();
        chk("r_ign_busy", 32'(busy), 1);
        send(8'h12, 1); send(8'h05, 1);
        send(8'hFF, 1); send(8'hEE, 1); send(8'h0A, 1);
        wait_end();
        chk("r_done", 32'(done), 1);
        chk("r_ww", 32'(words_written), 2);

        // Length too large
        pulse_start();
        send(8'hC9, 0); send(8'h00, 0);
        wait_end();
        chk("big_error", 32'(error), 1);
        chk("big_done", 32'(done), 0);
        chk("big_ww", 32'(words_written), 0);
        byte_valid = 1'b1;
        byte_data  = 8'h34;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("big_no_accept", 32'(byte_ready), 0);
        end
        byte_valid = 1'b0;

        // Bad top byte in the first word
        pulse_start();
        chk("e1_err_clr", 32'(error), 0);
        send(8'h02, 0); send(8'h00, 0);
        send(8'h34, 0); send(8'h12, 0); send(8'h15, 0);
        wait_end();
        chk("e1_error", 32'(error), 1);
        chk("e1_ww", 32'(words_written), 0);

        // Bad top byte in the third word after two good writes
        pulse_start();
        push(20'h0, 20'h51234);
        push(20'h4, 20'hAEEFF);
        send(8'h03, 0); send(8'h00, 0);
        send_two_words(0);
        send(8'h01, 0); send(8'h02, 0); send(8'h15, 0);
        wait_end();
        chk("e3_error", 32'(error), 1);
        chk("e3_ww", 32'(words_written), 2);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
